// File: rtl/csi_byte_aligner.sv
// csi_byte_aligner
// Finds the HS sync byte on one CSI-2 data lane at any of eight bit offsets,
// locks that offset, and then forwards byte-aligned data with a valid strobe
// until the next line reset. A sticky flag reports a search that runs too long.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// ST_SEARCH | scanning the 16-bit window for the sync byte; timeout running
// ST_LOCKED | offset frozen; one aligned byte forwarded per cycle
module csi_byte_aligner #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hB8,
   parameter int unsigned SEARCH_TIMEOUT = 64
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       line_reset_i,
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       locked_o,
   output logic [2:0] sync_offset_o,
   output logic       sync_timeout_o
);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Count value on which a further unmatched search cycle trips the timeout.
   localparam logic [15:0] TIMEOUT_LAST = 16'(SEARCH_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  prev_q;
   logic [15:0] window;
   logic [2:0]  offset_q, offset_d;
   logic [7:0]  byte_q, byte_d;
   logic        valid_q, valid_d;
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;
   logic        match_hit;
   logic [2:0]  match_k;
   logic [7:0]  locked_data;

   // Earlier byte sits in the low half, so candidate k spans window[k+7:k].
   assign window      = {byte_i, prev_q};
   assign locked_data = window[offset_q +: 8];

   // Previous byte is captured even during line reset so a sync that
   // straddles the reset release is still visible in the first window.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         prev_q <= 8'h00;
      end else begin
         prev_q <= byte_i;
      end
   end

   // Sync search across all eight offsets; scanning downwards leaves the
   // lowest matching offset as the winner.
   always_comb begin
      match_hit = 1'b0;
      match_k   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (window[k +: 8] == SYNC_BYTE) begin
            match_hit = 1'b1;
            match_k   = 3'(k);
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_SEARCH;
         offset_q  <= 3'd0;
         byte_q    <= 8'h00;
         valid_q   <= 1'b0;
         cnt_q     <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         offset_q  <= offset_d;
         byte_q    <= byte_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and next-output logic; line reset beats any match.
   always_comb begin
      state_d   = state_q;
      offset_d  = offset_q;
      byte_d    = byte_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;

      if (line_reset_i) begin
         state_d   = ST_SEARCH;
         offset_d  = 3'd0;
         byte_d    = 8'h00;
         valid_d   = 1'b0;
         cnt_d     = 16'd0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_SEARCH: begin
               if (match_hit) begin
                  // The sync byte itself is swallowed; data starts next edge.
                  state_d  = ST_LOCKED;
                  offset_d = match_k;
               end else begin
                  if (cnt_q != 16'hFFFF) begin
                     cnt_d = cnt_q + 16'd1;
                  end
                  if (cnt_q >= TIMEOUT_LAST) begin
                     timeout_d = 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               // No re-search: later sync patterns are ordinary payload.
               byte_d  = locked_data;
               valid_d = 1'b1;
            end
            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end
   end

   assign byte_o         = byte_q;
   assign byte_valid_o   = valid_q;
   assign locked_o       = (state_q == ST_LOCKED);
   assign sync_offset_o  = offset_q;
   assign sync_timeout_o = timeout_q;

endmodule

// File: tb/tb_csi_byte_aligner.sv
// Directed and randomized bench for csi_byte_aligner with a behavioural model.
module tb_csi_byte_aligner;

   localparam logic [7:0] SYNC = 8'hB8;
   localparam int         TMO  = 64;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       line_reset;
   logic [7:0] byte_in;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       locked;
   logic [2:0] sync_offset;
   logic       sync_timeout;

   csi_byte_aligner #(
      .SYNC_BYTE     (SYNC),
      .SEARCH_TIMEOUT(TMO)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .line_reset_i  (line_reset),
      .byte_i        (byte_in),
      .byte_o        (byte_out),
      .byte_valid_o  (byte_valid),
      .locked_o      (locked),
      .sync_offset_o (sync_offset),
      .sync_timeout_o(sync_timeout)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model: what the aligner should present after each edge.
   logic [7:0] m_prev   = 8'h00;
   logic [7:0] m_byte   = 8'h00;
   bit         m_valid  = 1'b0;
   bit         m_locked = 1'b0;
   bit         m_to     = 1'b0;
   int         m_off    = 0;
   int         m_unmatched = 0;

   task automatic model_edge(input logic [7:0] b, input logic lr, input logic rn);
      int unsigned w;
      int          found;
      w = (int'(b) << 8) + int'(m_prev);
      if (!rn) begin
         m_prev = 8'h00; m_byte = 8'h00; m_valid = 0; m_locked = 0;
         m_to = 0; m_off = 0; m_unmatched = 0;
      end else begin
         m_prev = b;
         if (lr) begin
            m_byte = 8'h00; m_valid = 0; m_locked = 0;
            m_to = 0; m_off = 0; m_unmatched = 0;
         end else if (m_locked) begin
            m_byte  = 8'((w >> m_off) & 32'hFF);
            m_valid = 1;
         end else begin
            found = -1;
            for (int k = 0; k < 8; k++) begin
               if (found < 0 && ((w >> k) & 32'hFF) == int'(SYNC)) found = k;
            end
            if (found >= 0) begin
               m_locked = 1;
               m_off    = found;
            end else begin
               m_unmatched++;
               if (m_unmatched >= TMO) m_to = 1;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after rising edge.
   task automatic step(input logic [7:0] b, input logic lr, input logic rn);
      @(negedge clk);
      byte_in    = b;
      line_reset = lr;
      reset_n    = rn;
      @(posedge clk);
      model_edge(b, lr, rn);
      #1;
      check("byte_o",         byte_out,            m_byte);
      check("byte_valid_o",   {7'd0, byte_valid},  {7'd0, m_valid});
      check("locked_o",       {7'd0, locked},      {7'd0, m_locked});
      check("sync_offset_o",  {5'd0, sync_offset}, 8'(m_off));
      check("sync_timeout_o", {7'd0, sync_timeout},{7'd0, m_to});
   endtask

   initial begin
      logic [15:0] pair;
      logic [7:0]  rb;
      logic        rlr, rrn;

      byte_in    = 8'h00;
      line_reset = 1'b1;
      reset_n    = 1'b0;

      // Reset state
      step(8'h00, 1'b0, 1'b0);
      step(8'h5A, 1'b1, 1'b0);
      check("reset_outputs", {byte_out[6:0], byte_valid | locked | sync_timeout}, 8'h00);

      // Offset 0: sync lands as the earlier byte of the window
      step(8'h00, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      step(8'hB8, 1'b0, 1'b1);
      step(8'h11, 1'b0, 1'b1);
      check("t1_locked", {7'd0, locked}, 8'h01);
      check("t1_offset", {5'd0, sync_offset}, 8'h00);
      check("t1_valid_on_match_edge", {7'd0, byte_valid}, 8'h00);
      step(8'h22, 1'b0, 1'b1);
      check("t1_first_byte", byte_out, 8'h11);
      check("t1_first_valid", {7'd0, byte_valid}, 8'h01);
      step(8'h33, 1'b0, 1'b1);
      check("t1_second_byte", byte_out, 8'h22);

      // Offset 3: window 0xD5C0
      step(8'h00, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      step(8'hC0, 1'b0, 1'b1);
      step(8'hD5, 1'b0, 1'b1);
      check("t2_offset", {5'd0, sync_offset}, 8'h03);
      step(8'h02, 1'b0, 1'b1);
      check("t2_first_byte", byte_out, 8'h5A);

      // 0xB8 cannot overlap a shifted copy of itself, so no window holds two
      // matches; here k=2 matches while k=0,1 carry near-miss patterns.
      step(8'h00, 1'b1, 1'b1);
      step(8'hE0, 1'b0, 1'b1);
      step(8'h02, 1'b0, 1'b1);
      check("t3_offset", {5'd0, sync_offset}, 8'h02);
      step(8'hB8, 1'b0, 1'b1);
      step(8'hB8, 1'b0, 1'b1);
      check("t3_sync_as_data_locked", {7'd0, locked}, 8'h01);

      // Line reset pulse mid-stream, then relock at offset 6 (window 0x2E00)
      step(8'h00, 1'b1, 1'b1);
      check("t4_valid_cleared", {7'd0, byte_valid}, 8'h00);
      check("t4_locked_cleared", {7'd0, locked}, 8'h00);
      step(8'h2E, 1'b0, 1'b1);
      check("t4_offset", {5'd0, sync_offset}, 8'h06);

      // Timeout after exactly 64 unmatched search cycles
      step(8'h00, 1'b1, 1'b1);
      for (int i = 0; i < TMO - 1; i++) step(8'h00, 1'b0, 1'b1);
      check("t5_no_timeout_at_63", {7'd0, sync_timeout}, 8'h00);
      step(8'h00, 1'b0, 1'b1);
      check("t5_timeout_at_64", {7'd0, sync_timeout}, 8'h01);
      step(8'hB8, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b1);
      check("t5_late_lock", {7'd0, locked}, 8'h01);
      check("t5_timeout_sticky", {7'd0, sync_timeout}, 8'h01);
      step(8'h00, 1'b1, 1'b1);
      check("t5_timeout_cleared", {7'd0, sync_timeout}, 8'h00);

      // Reset precedence while locked
      step(8'h00, 1'b0, 1'b1);
      step(8'hB8, 1'b0, 1'b1);
      step(8'h44, 1'b0, 1'b1);
      step(8'h55, 1'b0, 1'b1);
      step(8'h66, 1'b0, 1'b0);
      check("t6_reset_byte", byte_out, 8'h00);
      check("t6_reset_flags", {5'd0, byte_valid, locked, sync_timeout}, 8'h00);
      for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b1);
      check("t6_no_relock_without_sync", {7'd0, locked}, 8'h00);
      step(8'hB8, 1'b0, 1'b1);
      step(8'h77, 1'b0, 1'b1);
      check("t6_relock", {7'd0, locked}, 8'h01);

      // Randomized traffic with line resets, resets and injected syncs
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            pair = 16'(SYNC) << $urandom_range(0, 7);
            step(pair[7:0], 1'b0, 1'b1);
            step(pair[15:8], 1'b0, 1'b1);
         end else begin
            rb  = 8'($urandom);
            rlr = ($urandom_range(0, 39) == 0);
            rrn = ($urandom_range(0, 499) != 0);
            step(rb, rlr, rrn);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
